// File: rtl/valu_pkg.sv
// Shared constants for the vector-ALU scheduler: ALU operation codes and default datapath widths.
package valu_pkg;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_REP = 3'b010;
  localparam logic [2:0] ALU_MUL = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam int REG_WIDTH  = 256;
  localparam int ELEM_WIDTH = 32;
  localparam int NUM_ELEM   = REG_WIDTH / ELEM_WIDTH;

  typedef logic [REG_WIDTH-1:0] vreg_t;

endpackage

// File: rtl/valu_sched_if.sv
// Request, ALU and response signals of the vector-ALU scheduler.
// master = requesters/consumer/ALU side, slave = the scheduler.
interface valu_sched_if
  import valu_pkg::*;
#(
  parameter int NUM_REQ = 4
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ-1:0]           req_ready;
  logic [NUM_REQ*REG_WIDTH-1:0] req_a;
  logic [NUM_REQ*REG_WIDTH-1:0] req_b;
  logic [NUM_REQ-1:0]           req_useimm;
  logic [NUM_REQ*3-1:0]         req_ctrl;

  logic [REG_WIDTH-1:0]         alu_a;
  logic [REG_WIDTH-1:0]         alu_b;
  logic                         alu_useimm;
  logic [2:0]                   alu_ctrl;
  logic [REG_WIDTH-1:0]         alu_result;
  logic                         alu_zero;

  logic                         rsp_valid;
  logic                         rsp_ready;
  logic [ID_W-1:0]              rsp_id;
  logic [REG_WIDTH-1:0]         rsp_result;
  logic                         rsp_zero;

  modport master (
    output req_valid, req_a, req_b, req_useimm, req_ctrl, rsp_ready, alu_result, alu_zero,
    input  req_ready, alu_a, alu_b, alu_useimm, alu_ctrl, rsp_valid, rsp_id, rsp_result, rsp_zero
  );

  modport slave (
    input  req_valid, req_a, req_b, req_useimm, req_ctrl, rsp_ready, alu_result, alu_zero,
    output req_ready, alu_a, alu_b, alu_useimm, alu_ctrl, rsp_valid, rsp_id, rsp_result, rsp_zero
  );

endinterface

// File: rtl/valu_rr_arb.sv
// Round-robin arbiter with a last-grant pointer. The search starts at ptr+1.
// With VALU_SCHED_FIXED_PRIO_EN defined, requester 0 always wins and the rotation only covers 1..NUM_REQ-1.
module valu_rr_arb #(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en_i,
  input  logic [NUM_REQ-1:0] req_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic               gnt_vld_o,
  output logic [ID_W-1:0]    gnt_idx_o
);

  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [NUM_REQ-1:0] rr_req;
  logic               rr_hit;
  logic [ID_W-1:0]    rr_idx;

  always_comb begin
    rr_req = req_i;
`ifdef VALU_SCHED_FIXED_PRIO_EN
    rr_req[0] = 1'b0;
`endif
    rr_hit = 1'b0;
    rr_idx = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!rr_hit && rr_req[(int'(ptr_q) + k) % NUM_REQ]) begin
        rr_hit = 1'b1;
        rr_idx = ID_W'((int'(ptr_q) + k) % NUM_REQ);
      end
    end
  end

  // No grant may leave while reset is high, even though en_i is combinational.
  always_comb begin
    gnt_vld_o = 1'b0;
    gnt_idx_o = rr_idx;
    ptr_d     = ptr_q;
    if (en_i && !reset) begin
`ifdef VALU_SCHED_FIXED_PRIO_EN
      if (req_i[0]) begin
        gnt_vld_o = 1'b1;
        gnt_idx_o = '0;
      end else
`endif
      if (rr_hit) begin
        gnt_vld_o = 1'b1;
        ptr_d     = rr_idx;
      end
    end
    gnt_o = gnt_vld_o ? (NUM_REQ'(1) << gnt_idx_o) : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q <= ID_W'(NUM_REQ - 1);
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/valu_sched.sv
// Shares one vector ALU among NUM_REQ requesters via an ISS register stage and an RSP stage (accept N -> rsp N+2).
// Build option: VALU_SCHED_FIXED_PRIO_EN gives requester 0 absolute priority.
module valu_sched
  import valu_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input logic         clk,
  input logic         reset,
  valu_sched_if.slave bus
);

  localparam int ID_W = $clog2(NUM_REQ);

  logic            rsp_adv;
  logic            iss_adv;
  logic            gnt_vld;
  logic [ID_W-1:0] gnt_idx;

  logic            iss_valid_q, iss_valid_d;
  logic [ID_W-1:0] iss_id_q, iss_id_d;
  vreg_t           iss_a_q, iss_a_d;
  vreg_t           iss_b_q, iss_b_d;
  logic            iss_useimm_q, iss_useimm_d;
  logic [2:0]      iss_ctrl_q, iss_ctrl_d;

  logic            rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0] rsp_id_q, rsp_id_d;
  vreg_t           rsp_result_q, rsp_result_d;
  logic            rsp_zero_q, rsp_zero_d;

  assign rsp_adv = !rsp_valid_q || bus.rsp_ready;
  assign iss_adv = !iss_valid_q || rsp_adv;

  valu_rr_arb #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .clk       (clk),
    .reset     (reset),
    .en_i      (iss_adv),
    .req_i     (bus.req_valid),
    .gnt_o     (bus.req_ready),
    .gnt_vld_o (gnt_vld),
    .gnt_idx_o (gnt_idx)
  );

  always_comb begin
    iss_valid_d  = iss_valid_q;
    iss_id_d     = iss_id_q;
    iss_a_d      = iss_a_q;
    iss_b_d      = iss_b_q;
    iss_useimm_d = iss_useimm_q;
    iss_ctrl_d   = iss_ctrl_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_zero_d   = rsp_zero_q;

    if (iss_adv) begin
      iss_valid_d = gnt_vld;
      if (gnt_vld) begin
        iss_id_d     = gnt_idx;
        iss_a_d      = bus.req_a[int'(gnt_idx)*REG_WIDTH +: REG_WIDTH];
        iss_b_d      = bus.req_b[int'(gnt_idx)*REG_WIDTH +: REG_WIDTH];
        iss_useimm_d = bus.req_useimm[gnt_idx];
        iss_ctrl_d   = bus.req_ctrl[int'(gnt_idx)*3 +: 3];
      end
    end

    // The ALU is combinational on the ISS registers, so its result is captured on the ISS->RSP move.
    if (rsp_adv) begin
      rsp_valid_d = iss_valid_q;
      if (iss_valid_q) begin
        rsp_id_d     = iss_id_q;
        rsp_result_d = bus.alu_result;
        rsp_zero_d   = bus.alu_zero;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      iss_valid_q  <= 1'b0;
      iss_id_q     <= '0;
      iss_a_q      <= '0;
      iss_b_q      <= '0;
      iss_useimm_q <= 1'b0;
      iss_ctrl_q   <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
    end else begin
      iss_valid_q  <= iss_valid_d;
      iss_id_q     <= iss_id_d;
      iss_a_q      <= iss_a_d;
      iss_b_q      <= iss_b_d;
      iss_useimm_q <= iss_useimm_d;
      iss_ctrl_q   <= iss_ctrl_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_zero_q   <= rsp_zero_d;
    end
  end

  assign bus.alu_a      = iss_a_q;
  assign bus.alu_b      = iss_b_q;
  assign bus.alu_useimm = iss_useimm_q;
  assign bus.alu_ctrl   = iss_ctrl_q;

  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_zero   = rsp_zero_q;

endmodule

// File: tb/tb_valu_sched.sv
// Directed bench for valu_sched with a behavioural lane-wise ALU model.
module tb_valu_sched;
  import valu_pkg::*;

  localparam int NR = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  valu_sched_if #(.NUM_REQ(NR)) bus ();

  valu_sched #(.NUM_REQ(NR)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  vreg_t      op_a   [NR];
  vreg_t      op_b   [NR];
  logic [2:0] op_ctrl[NR];
  logic       op_imm [NR];

  always_comb begin
    for (int i = 0; i < NR; i++) begin
      bus.req_a[i*REG_WIDTH +: REG_WIDTH] = op_a[i];
      bus.req_b[i*REG_WIDTH +: REG_WIDTH] = op_b[i];
      bus.req_ctrl[i*3 +: 3]              = op_ctrl[i];
      bus.req_useimm[i]                   = op_imm[i];
    end
  end

  always_comb begin : alu_model
    logic [ELEM_WIDTH-1:0] ea, eb, er;
    vreg_t res;
    res = '0;
    ea  = '0;
    eb  = '0;
    er  = '0;
    for (int l = 0; l < NUM_ELEM; l++) begin
      ea = bus.alu_a[l*ELEM_WIDTH +: ELEM_WIDTH];
      eb = bus.alu_useimm ? bus.alu_b[ELEM_WIDTH-1:0] : bus.alu_b[l*ELEM_WIDTH +: ELEM_WIDTH];
      case (bus.alu_ctrl)
        ALU_ADD: er = ea + eb;
        ALU_SUB: er = ea - eb;
        ALU_REP: er = eb;
        ALU_MUL: er = ea * eb;
        ALU_SLT: er = ($signed(ea) < $signed(eb)) ? 32'd1 : 32'd0;
        default: er = '0;
      endcase
      res[l*ELEM_WIDTH +: ELEM_WIDTH] = er;
    end
    bus.alu_result = res;
    bus.alu_zero   = (res == '0);
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input vreg_t act, input vreg_t exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vreg_t bcast(input logic [31:0] v);
    return {NUM_ELEM{v}};
  endfunction

  task automatic step(input logic [NR-1:0] v, input logic rr);
    @(negedge clk);
    bus.req_valid = v;
    bus.rsp_ready = rr;
    #2;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  typedef struct {
    logic [NR-1:0] v;
    logic          rr;
    logic [NR-1:0] exp_rdy;
    logic          exp_rv;
    logic [1:0]    exp_id;
  } vec_t;

  vec_t tbl[14];

  initial begin
    reset         = 1'b1;
    bus.req_valid = '1;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < NR; i++) begin
      op_a[i] = '0; op_b[i] = '0; op_ctrl[i] = ALU_ADD; op_imm[i] = 1'b0;
    end

    tbl[0]  = '{4'b1111, 1'b1, 4'b0001, 1'b0, 2'd0};
    tbl[1]  = '{4'b1111, 1'b1, 4'b0010, 1'b0, 2'd0};
    tbl[2]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 2'd0};
    tbl[3]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 2'd1};
    tbl[4]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd2};
    tbl[5]  = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2'd3};
    tbl[6]  = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2'd0};
    tbl[7]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0};
    tbl[8]  = '{4'b0100, 1'b1, 4'b0100, 1'b0, 2'd0};
    tbl[9]  = '{4'b1010, 1'b1, 4'b1000, 1'b0, 2'd0};
    tbl[10] = '{4'b0010, 1'b1, 4'b0010, 1'b1, 2'd2};
    tbl[11] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2'd3};
    tbl[12] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2'd1};
    tbl[13] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0};

    // Reset state, with every requester asking.
    @(negedge clk);
    chk("rst_req_ready", bus.req_ready, '0);
    chk("rst_rsp_valid", bus.rsp_valid, '0);
    chk("rst_rsp_result", bus.rsp_result, '0);
    chk("rst_alu_a", bus.alu_a, '0);
    chk("rst_alu_ctrl", bus.alu_ctrl, '0);
    bus.req_valid = '0;
    reset = 1'b0;

    // Single ADD: 5 + 3 on every lane.
    op_a[0] = bcast(32'd5); op_b[0] = bcast(32'd3); op_ctrl[0] = ALU_ADD;
    step(4'b0001, 1'b1);
    chk("add_ready", bus.req_ready, 4'b0001);
    step(4'b0000, 1'b1);
    chk("add_rv_n1", bus.rsp_valid, 1'b0);
    chk("add_alu_a", bus.alu_a, bcast(32'd5));
    chk("add_alu_ctrl", bus.alu_ctrl, ALU_ADD);
    step(4'b0000, 1'b1);
    chk("add_rv_n2", bus.rsp_valid, 1'b1);
    chk("add_result", bus.rsp_result, bcast(32'd8));
    chk("add_id", bus.rsp_id, 2'd0);
    chk("add_zero", bus.rsp_zero, 1'b0);
    step(4'b0000, 1'b1);
    chk("add_drained", bus.rsp_valid, 1'b0);

`ifndef VALU_SCHED_FIXED_PRIO_EN
    // Round-robin: requester i computes (i+1)+10 per lane.
    do_reset();
    for (int i = 0; i < NR; i++) begin
      op_a[i] = bcast(32'(i + 1)); op_b[i] = bcast(32'd10); op_ctrl[i] = ALU_ADD; op_imm[i] = 1'b0;
    end
    for (int r = 0; r < 14; r++) begin
      step(tbl[r].v, tbl[r].rr);
      chk($sformatf("rr%0d_ready", r), bus.req_ready, tbl[r].exp_rdy);
      chk($sformatf("rr%0d_rsp_valid", r), bus.rsp_valid, tbl[r].exp_rv);
      if (tbl[r].exp_rv) begin
        chk($sformatf("rr%0d_rsp_id", r), bus.rsp_id, tbl[r].exp_id);
        chk($sformatf("rr%0d_result", r), bus.rsp_result, bcast(32'(tbl[r].exp_id) + 32'd11));
      end
    end
`else
    // Fixed priority: requester 0 keeps winning until it goes idle.
    do_reset();
    for (int c = 0; c < 3; c++) begin
      step(4'b0101, 1'b1);
      chk($sformatf("fp%0d_ready", c), bus.req_ready, 4'b0001);
    end
    step(4'b0100, 1'b1);
    chk("fp_req2_ready", bus.req_ready, 4'b0100);
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b1);
`endif

    // Backpressure plus zero flag and broadcast immediate.
    op_a[1] = bcast(32'd7);   op_b[1] = bcast(32'd7);  op_ctrl[1] = ALU_SUB; op_imm[1] = 1'b0;
    op_a[2] = bcast(32'd123); op_b[2] = bcast(32'hDEAD0000); op_b[2][31:0] = 32'd9;
    op_ctrl[2] = ALU_REP; op_imm[2] = 1'b1;
    op_a[3] = bcast(32'd100); op_b[3] = bcast(32'd23); op_ctrl[3] = ALU_ADD; op_imm[3] = 1'b0;
    step(4'b0010, 1'b1);
    chk("bp_acc1", bus.req_ready, 4'b0010);
    step(4'b0100, 1'b1);
    chk("bp_acc2", bus.req_ready, 4'b0100);
    for (int c = 0; c < 3; c++) begin
      step(4'b1000, 1'b0);
      chk($sformatf("bp%0d_ready", c), bus.req_ready, 4'b0000);
      chk($sformatf("bp%0d_rsp_valid", c), bus.rsp_valid, 1'b1);
      chk($sformatf("bp%0d_rsp_id", c), bus.rsp_id, 2'd1);
      chk($sformatf("bp%0d_result", c), bus.rsp_result, '0);
      chk($sformatf("bp%0d_zero", c), bus.rsp_zero, 1'b1);
      chk($sformatf("bp%0d_alu_imm", c), bus.alu_useimm, 1'b1);
    end
    step(4'b1000, 1'b1);
    chk("bp_rel_ready", bus.req_ready, 4'b1000);
    chk("bp_rel_id", bus.rsp_id, 2'd1);
    step(4'b0000, 1'b1);
    chk("imm_rsp_id", bus.rsp_id, 2'd2);
    chk("imm_result", bus.rsp_result, bcast(32'd9));
    chk("imm_zero", bus.rsp_zero, 1'b0);
    step(4'b0000, 1'b1);
    chk("bp3_rsp_id", bus.rsp_id, 2'd3);
    chk("bp3_result", bus.rsp_result, bcast(32'd123));
    step(4'b0000, 1'b1);
    chk("bp_drained", bus.rsp_valid, 1'b0);

    // Reset with both stages occupied.
    op_a[0] = bcast(32'd5); op_b[0] = bcast(32'd3); op_ctrl[0] = ALU_ADD;
    step(4'b0001, 1'b1);
    chk("mr_acc0", bus.req_ready, 4'b0001);
    step(4'b0010, 1'b0);
    chk("mr_acc1", bus.req_ready, 4'b0010);
    step(4'b1111, 1'b0);
    chk("mr_full_ready", bus.req_ready, 4'b0000);
    chk("mr_full_rv", bus.rsp_valid, 1'b1);
    chk("mr_full_ctrl", bus.alu_ctrl, ALU_SUB);
    reset = 1'b1;
    #1;
    chk("mr_rv", bus.rsp_valid, 1'b0);
    chk("mr_alu_a", bus.alu_a, '0);
    chk("mr_alu_b", bus.alu_b, '0);
    chk("mr_alu_ctrl", bus.alu_ctrl, '0);
    chk("mr_result", bus.rsp_result, '0);
    chk("mr_ready", bus.req_ready, '0);
    @(negedge clk);
    chk("mr_ready_hold", bus.req_ready, '0);
    reset = 1'b0;
    bus.rsp_ready = 1'b1;
    #2;
    chk("mr_first_gnt", bus.req_ready, 4'b0001);
`ifndef VALU_SCHED_FIXED_PRIO_EN
    step(4'b1110, 1'b1);
    chk("mr_gnt1", bus.req_ready, 4'b0010);
    chk("mr_no_stale", bus.rsp_valid, 1'b0);
    step(4'b1100, 1'b1);
    chk("mr_rsp0_id", bus.rsp_id, 2'd0);
    chk("mr_rsp0_res", bus.rsp_result, bcast(32'd8));
    step(4'b1000, 1'b1);
    chk("mr_rsp1_id", bus.rsp_id, 2'd1);
    chk("mr_rsp1_zero", bus.rsp_zero, 1'b1);
`endif
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
